vga_scan_compositor: RTL and testbench

Raster scan source and final pixel stage of the video pipeline. Free-running horizontal/vertical counters generate 640x480@60 timing and drive `x`, `y`, `active` into the overlay generators. A registered output stage takes the returned 6-bit overlay colour, keys out the transparent code against a background colour, and emits `rgb_out` with `hsync_out`/`vsync_out` aligned to it.

---
 rtl/vga_scan_compositor_pkg.sv | 56 +++++
 rtl/vga_timing_counter.sv | 85 ++++++++
 rtl/vga_scan_compositor.sv | 92 +++++++++
 tb/tb_vga_scan_compositor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_compositor_pkg.sv
// ---------------------------------------------------------------------------
// vga_scan_compositor_pkg
//
// Shared video package for the scan source, the compositor and the overlay
// generators. Holds the default 640x480@60 timing constants, the 6-bit
// RRGGBB colour type, the transparent key code and a few named colours.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package vga_scan_compositor_pkg;

    // 6-bit colour, two bits per channel, RRGGBB
    typedef logic [5:0] color_t;

    // Raster coordinate / counter width
    typedef logic [9:0] coord_t;

    // Default horizontal timing (pixels)
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Default vertical timing (lines)
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Code an overlay returns when it has nothing to draw at a pixel
    localparam color_t VGA_KEY_COLOR = 6'b100001;

    // Named colours
    localparam color_t COLOR_BLACK = 6'b000000;
    localparam color_t COLOR_WHITE = 6'b111111;

    // Final pixel choice: blank outside the visible area, otherwise the
    // overlay unless it returned the key code, in which case the background.
    function automatic color_t key_select(input logic   active,
                                          input color_t overlay,
                                          input color_t bg,
                                          input color_t key);
        color_t result;
        if (!active) begin
            result = COLOR_BLACK;
        end else if (overlay == key) begin
            result = bg;
        end else begin
            result = overlay;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_timing_counter
//
// Free-running horizontal/vertical raster counters with the decodes that
// hang directly off them. Everything decoded here is a pure function of the
// counter registers, so downstream logic sees no combinational input path.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   ena          in   advance enable; low holds counters and frame_count
//   h_count      out  current column
//   v_count      out  current row
//   active       out  inside the visible area
//   frame_start  out  high while (h,v) == (0,0)
//   hsync_n      out  unregistered active-low hsync decode
//   vsync_n      out  unregistered active-low vsync decode
//   frame_count  out  completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_timing_counter
    import vga_scan_compositor_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output coord_t     h_count,
    output coord_t     v_count,
    output logic       active,
    output logic       frame_start,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Boundaries pre-sized to the counter width so every compare is 10-bit unsigned
    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Raster walk: h steps every enabled cycle, v steps when h wraps, and the
    // frame counter steps on the single edge where both wrap together.
    // Reset wins over ena so a mid-frame reset always restarts at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            frame_count <= '0;
        end else if (ena) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                if (v_count == V_LAST) begin
                    v_count     <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    v_count <= v_count + 10'd1;
                end
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    assign active      = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    assign frame_start = (h_count == '0) && (v_count == '0);
    assign hsync_n     = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
    assign vsync_n     = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));

endmodule

// File: rtl/vga_scan_compositor.sv
// ---------------------------------------------------------------------------
// vga_scan_compositor
//
// Raster scan source and final pixel stage. The timing counter drives x, y
// and active out to the overlay generators; their same-cycle colour comes
// back in, is keyed against the background and registered together with
// the sync decodes so rgb_out, hsync_out and vsync_out all describe the
// same counter cycle, one clock later.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   ena          in   advance enable; low freezes all state
//   x, y         out  current column / row
//   active       out  inside the visible area
//   overlay_rgb  in   overlay colour for current x,y
//   bg_rgb       in   background colour for current x,y
//   rgb_out      out  registered pixel colour
//   hsync_out    out  registered active-low hsync
//   vsync_out    out  registered active-low vsync
//   frame_start  out  high while the counters sit at (0,0)
//   frame_count  out  completed-frame counter
// ---------------------------------------------------------------------------
module vga_scan_compositor
    import vga_scan_compositor_pkg::*;
#(
    parameter int     H_VISIBLE = VGA_H_VISIBLE,
    parameter int     H_FRONT   = VGA_H_FRONT,
    parameter int     H_SYNC    = VGA_H_SYNC,
    parameter int     H_BACK    = VGA_H_BACK,
    parameter int     V_VISIBLE = VGA_V_VISIBLE,
    parameter int     V_FRONT   = VGA_V_FRONT,
    parameter int     V_SYNC    = VGA_V_SYNC,
    parameter int     V_BACK    = VGA_V_BACK,
    parameter color_t KEY_COLOR = VGA_KEY_COLOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    input  logic [5:0] overlay_rgb,
    input  logic [5:0] bg_rgb,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    logic hsync_n;
    logic vsync_n;

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .h_count     (x),
        .v_count     (y),
        .active      (active),
        .frame_start (frame_start),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_count (frame_count)
    );

    // Output stage: colour and both syncs are captured on the same enabled
    // edge, which keeps them aligned to one counter cycle. Holding on !ena
    // means a stall repeats nothing and skips nothing downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= COLOR_BLACK;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (ena) begin
            rgb_out   <= key_select(active, overlay_rgb, bg_rgb, KEY_COLOR);
            hsync_out <= hsync_n;
            vsync_out <= vsync_n;
        end
    end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_compositor
//
// Self-checking bench for vga_scan_compositor. The DUT is built with a
// shrunken raster (15 x 8, 120 pixels per frame) so that more than 256
// frames fit in a short run. The reference model tracks only the number of
// enabled cycles since reset and derives every output from it with plain
// division and modulo.
// ---------------------------------------------------------------------------
module tb_vga_scan_compositor;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [5:0] KEY = 6'b100001;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic [5:0] overlay_rgb;
    logic [5:0] bg_rgb;
    logic [5:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       frame_start;
    logic [7:0] frame_count;

    // Model state: enabled cycles since reset plus the expected output registers
    int         model_n;
    logic [5:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;

    int tests;
    int failures;

    always #5 clk = ~clk;

    vga_scan_compositor #(
        .H_VISIBLE (HV),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB),
        .KEY_COLOR (KEY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .x           (x),
        .y           (y),
        .active      (active),
        .overlay_rgb (overlay_rgb),
        .bg_rgb      (bg_rgb),
        .rgb_out     (rgb_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at n=%0d: got %0h, expected %0h",
                     tag, model_n, observed, expected);
        end
    endtask

    // Compare every DUT output against the model for the current state
    task automatic checkAll();
        int h;
        int v;
        h = model_n % HT;
        v = (model_n / HT) % VT;
        checkOutput("x", 32'(x), 32'(h));
        checkOutput("y", 32'(y), 32'(v));
        checkOutput("active", 32'(active), 32'((h < HV) && (v < VV)));
        checkOutput("frame_start", 32'(frame_start), 32'((model_n % FRAME) == 0));
        checkOutput("frame_count", 32'(frame_count), 32'((model_n / FRAME) % 256));
        checkOutput("rgb_out", 32'(rgb_out), 32'(exp_rgb));
        checkOutput("hsync_out", 32'(hsync_out), 32'(exp_hs));
        checkOutput("vsync_out", 32'(vsync_out), 32'(exp_vs));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [5:0] ov, input logic [5:0] bg);
        int h;
        int v;
        rst         = r;
        ena         = e;
        overlay_rgb = ov;
        bg_rgb      = bg;
        @(posedge clk);
        if (r) begin
            model_n = 0;
            exp_rgb = 6'd0;
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
        end else if (e) begin
            h = model_n % HT;
            v = (model_n / HT) % VT;
            if (!((h < HV) && (v < VV)))
                exp_rgb = 6'd0;
            else if (ov == KEY)
                exp_rgb = bg;
            else
                exp_rgb = ov;
            exp_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
            exp_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            model_n = model_n + 1;
        end
        #1;
        checkAll();
    endtask

    // Random overlay colour with a healthy share of key codes
    function automatic logic [5:0] randOverlay();
        if ($urandom_range(3) == 0)
            return KEY;
        return 6'($urandom);
    endfunction

    initial begin
        tests       = 0;
        failures    = 0;
        model_n     = 0;
        exp_rgb     = 6'd0;
        exp_hs      = 1'b1;
        exp_vs      = 1'b1;
        rst         = 1'b1;
        ena         = 1'b0;
        overlay_rgb = 6'd0;
        bg_rgb      = 6'd0;

        // Reset state, then directed keying at the first visible pixels
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
        applyStimulus(1'b1, 1'b1, 6'd0, 6'd0);
        applyStimulus(1'b0, 1'b1, KEY, 6'b000011);
        applyStimulus(1'b0, 1'b1, 6'b110110, 6'b000011);

        // Advance to the pixel just before hsync, stall 5 cycles, resume
        for (int i = 0; i < HT && (model_n % HT) != (HV + HF - 1); i++)
            applyStimulus(1'b0, 1'b1, randOverlay(), 6'($urandom));
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, randOverlay(), 6'($urandom));
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, randOverlay(), 6'($urandom));

        // Mid-frame reset with ena low must still restart the raster
        for (int i = 0; i < 3 * HT + 5; i++)
            applyStimulus(1'b0, 1'b1, randOverlay(), 6'($urandom));
        applyStimulus(1'b1, 1'b0, randOverlay(), 6'($urandom));

        // Random phase: random enable, colours and occasional resets
        for (int i = 0; i < 3000; i++)
            applyStimulus(($urandom_range(499) == 0), ($urandom_range(9) < 8),
                          randOverlay(), 6'($urandom));

        // Long run past 256 frames so frame_count wraps 255 -> 0
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
        for (int i = 0; i < 40000 && model_n < 257 * FRAME + 10; i++)
            applyStimulus(1'b0, ($urandom_range(9) != 0), randOverlay(), 6'($urandom));
        checkOutput("wrap_reached", 32'(model_n >= 257 * FRAME + 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
